temp_disp_ctrl: RTL and testbench

Display scheduler between the I2C temperature path and the 8-digit seven-segment driver. Captures each new Celsius/Fahrenheit sample atomically and tracks Fahrenheit min/max. Sequences which quantity the display shows (C, F, max F, min F) by button or on an automatic dwell timer. Blanks the display when no sample exists or samples go stale.

---
 rtl/temp_disp_ctrl.sv | 170 +++++++++++++++++
 tb/tb_temp_disp_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_disp_ctrl.sv
// Display scheduler for the temperature readout: latches C/F samples, tracks min/max F,
// and sequences the shown view by button or dwell timer, blanking on missing/stale data.
module temp_disp_ctrl #(
   parameter int DWELL_CYCLES = 300_000_000,
   parameter int STALE_CYCLES = 200_000_000
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic [7:0] c_data,
   input  logic [7:0] f_data,
   input  logic       sample_valid,
   input  logic       btn_next,
   input  logic       btn_auto,
   input  logic       clear_mm,
   output logic [7:0] disp_data,
   output logic [1:0] disp_unit,
   output logic       disp_blank,
   output logic       sample_ack
);

   localparam int DW = $clog2(DWELL_CYCLES);
   localparam int SW = $clog2(STALE_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [SW-1:0] STALE_LAST = SW'(STALE_CYCLES - 1);

   localparam logic [2:0] NO_DATA  = 3'd0;
   localparam logic [2:0] SHOW_C   = 3'd1;
   localparam logic [2:0] SHOW_F   = 3'd2;
   localparam logic [2:0] SHOW_MAX = 3'd3;
   localparam logic [2:0] SHOW_MIN = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [SW-1:0] stale_q, stale_d;
   logic [7:0]    c_q, f_q, max_q, max_d, min_q, min_d;
   logic          mm_valid_q, mm_valid_d;
   logic          btn_next_q, clear_mm_q;
   logic          ack_pend_q, sample_ack_q;
   logic [7:0]    disp_data_q, disp_data_d;
   logic [1:0]    disp_unit_q, disp_unit_d;
   logic          disp_blank_q, disp_blank_d;

   logic next_edge, clear_edge, showing, dwell_done, advance, stale;

   assign next_edge  = btn_next & ~btn_next_q;
   assign clear_edge = clear_mm & ~clear_mm_q;
   assign showing    = (state_q != NO_DATA);
   assign dwell_done = (dwell_q == DWELL_LAST);
   // Button and timer expiry are OR-ed so a coincidence still yields a single step.
   assign advance    = showing & (next_edge | (btn_auto & dwell_done));
   assign stale      = (stale_q == STALE_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         NO_DATA:  if (sample_valid) state_d = SHOW_C;
         SHOW_C:   if (advance) state_d = SHOW_F;
         SHOW_F:   if (advance) state_d = SHOW_MAX;
         SHOW_MAX: if (advance) state_d = SHOW_MIN;
         SHOW_MIN: if (advance) state_d = SHOW_C;
         default:  state_d = NO_DATA;
      endcase
   end

   always_comb begin
      if (!showing || !btn_auto || advance) dwell_d = '0;
      else                                  dwell_d = dwell_q + DW'(1);
   end

   always_comb begin
      if (sample_valid) stale_d = '0;
      else if (stale)   stale_d = stale_q;
      else              stale_d = stale_q + SW'(1);
   end

   // A clear coinciding with a sample lets that sample seed min/max.
   always_comb begin
      max_d      = max_q;
      min_d      = min_q;
      mm_valid_d = mm_valid_q;
      if (sample_valid) begin
         if (!mm_valid_q || clear_edge) begin
            max_d = f_data;
            min_d = f_data;
         end else begin
            if (f_data > max_q) max_d = f_data;
            if (f_data < min_q) min_d = f_data;
         end
         mm_valid_d = 1'b1;
      end else if (clear_edge) begin
         mm_valid_d = 1'b0;
      end
   end

   always_comb begin
      disp_data_d  = 8'd0;
      disp_unit_d  = 2'd0;
      disp_blank_d = stale;
      case (state_q)
         SHOW_C: begin
            disp_data_d = c_q;
            disp_unit_d = 2'd0;
         end
         SHOW_F: begin
            disp_data_d = f_q;
            disp_unit_d = 2'd1;
         end
         SHOW_MAX: begin
            disp_data_d  = max_q;
            disp_unit_d  = 2'd2;
            disp_blank_d = stale | ~mm_valid_q;
         end
         SHOW_MIN: begin
            disp_data_d  = min_q;
            disp_unit_d  = 2'd3;
            disp_blank_d = stale | ~mm_valid_q;
         end
         default: begin
            disp_data_d  = 8'd0;
            disp_unit_d  = 2'd0;
            disp_blank_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q      <= NO_DATA;
         dwell_q      <= '0;
         stale_q      <= '0;
         c_q          <= 8'd0;
         f_q          <= 8'd0;
         max_q        <= 8'd0;
         min_q        <= 8'd0;
         mm_valid_q   <= 1'b0;
         btn_next_q   <= 1'b0;
         clear_mm_q   <= 1'b0;
         ack_pend_q   <= 1'b0;
         sample_ack_q <= 1'b0;
         disp_data_q  <= 8'd0;
         disp_unit_q  <= 2'd0;
         disp_blank_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         dwell_q      <= dwell_d;
         stale_q      <= stale_d;
         if (sample_valid) begin
            c_q <= c_data;
            f_q <= f_data;
         end
         max_q        <= max_d;
         min_q        <= min_d;
         mm_valid_q   <= mm_valid_d;
         btn_next_q   <= btn_next;
         clear_mm_q   <= clear_mm;
         // Ack is delayed one extra edge so it lines up with the refreshed display.
         ack_pend_q   <= sample_valid;
         sample_ack_q <= ack_pend_q;
         disp_data_q  <= disp_data_d;
         disp_unit_q  <= disp_unit_d;
         disp_blank_q <= disp_blank_d;
      end
   end

   assign disp_data  = disp_data_q;
   assign disp_unit  = disp_unit_q;
   assign disp_blank = disp_blank_q;
   assign sample_ack = sample_ack_q;

endmodule

// File: tb/tb_temp_disp_ctrl.sv
// Directed self-checking bench for temp_disp_ctrl with short dwell/stale periods.
module tb_temp_disp_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] c_data = 8'd0;
   logic [7:0] f_data = 8'd0;
   logic       sample_valid = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_auto = 1'b0;
   logic       clear_mm = 1'b0;
   logic [7:0] disp_data;
   logic [1:0] disp_unit;
   logic       disp_blank;
   logic       sample_ack;

   int n_checks = 0;
   int n_fail   = 0;

   temp_disp_ctrl #(.DWELL_CYCLES(10), .STALE_CYCLES(50)) dut (
      .clk_100MHz  (clk),
      .reset       (reset),
      .c_data      (c_data),
      .f_data      (f_data),
      .sample_valid(sample_valid),
      .btn_next    (btn_next),
      .btn_auto    (btn_auto),
      .clear_mm    (clear_mm),
      .disp_data   (disp_data),
      .disp_unit   (disp_unit),
      .disp_blank  (disp_blank),
      .sample_ack  (sample_ack)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_sample(input logic [7:0] c, input logic [7:0] f);
      c_data = c;
      f_data = f;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic press_next();
      btn_next = 1'b1;
      tick();
      btn_next = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick();
      n_checks++;
      if (disp_blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank: got %0b expected 1", disp_blank); end
      n_checks++;
      if (disp_data !== 8'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", disp_data); end
      n_checks++;
      if (disp_unit !== 2'd0) begin n_fail++; $display("FAIL reset_unit: got %0d expected 0", disp_unit); end
      n_checks++;
      if (sample_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %0b expected 0", sample_ack); end
      press_next();
      press_next();
      n_checks++;
      if (disp_blank !== 1'b1 || disp_unit !== 2'd0)
         begin n_fail++; $display("FAIL nodata_btn: got blank=%0b unit=%0d expected blank=1 unit=0", disp_blank, disp_unit); end
   endtask

   task automatic test_first_sample();
      send_sample(8'd22, 8'd71);
      n_checks++;
      if (sample_ack !== 1'b0) begin n_fail++; $display("FAIL ack_early: got %0b expected 0", sample_ack); end
      tick();
      n_checks++;
      if (sample_ack !== 1'b1) begin n_fail++; $display("FAIL ack_pulse: got %0b expected 1", sample_ack); end
      n_checks++;
      if (disp_data !== 8'd22 || disp_unit !== 2'd0 || disp_blank !== 1'b0)
         begin n_fail++; $display("FAIL first_view: got data=%0d unit=%0d blank=%0b expected 22/0/0", disp_data, disp_unit, disp_blank); end
      tick();
      n_checks++;
      if (sample_ack !== 1'b0) begin n_fail++; $display("FAIL ack_width: got %0b expected 0", sample_ack); end
      btn_next = 1'b1;
      tick();
      btn_next = 1'b0;
      n_checks++;
      if (disp_unit !== 2'd0) begin n_fail++; $display("FAIL btn_latency: got unit=%0d expected 0", disp_unit); end
      tick();
      n_checks++;
      if (disp_data !== 8'd71 || disp_unit !== 2'd1)
         begin n_fail++; $display("FAIL show_f: got data=%0d unit=%0d expected 71/1", disp_data, disp_unit); end
   endtask

   task automatic test_back_to_back();
      c_data = 8'd20; f_data = 8'd80; sample_valid = 1'b1;
      tick();
      c_data = 8'd18; f_data = 8'd65;
      tick();
      sample_valid = 1'b0;
      n_checks++;
      if (sample_ack !== 1'b1 || disp_data !== 8'd80)
         begin n_fail++; $display("FAIL b2b_first: got ack=%0b data=%0d expected 1/80", sample_ack, disp_data); end
      tick();
      n_checks++;
      if (sample_ack !== 1'b1 || disp_data !== 8'd65)
         begin n_fail++; $display("FAIL b2b_second: got ack=%0b data=%0d expected 1/65", sample_ack, disp_data); end
      tick();
      n_checks++;
      if (sample_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got ack=%0b expected 0", sample_ack); end
   endtask

   task automatic test_minmax();
      press_next();
      n_checks++;
      if (disp_data !== 8'd80 || disp_unit !== 2'd2 || disp_blank !== 1'b0)
         begin n_fail++; $display("FAIL max_80: got data=%0d unit=%0d blank=%0b expected 80/2/0", disp_data, disp_unit, disp_blank); end
      press_next();
      n_checks++;
      if (disp_data !== 8'd65 || disp_unit !== 2'd3)
         begin n_fail++; $display("FAIL min_65: got data=%0d unit=%0d expected 65/3", disp_data, disp_unit); end
      clear_mm = 1'b1;
      tick();
      clear_mm = 1'b0;
      tick();
      n_checks++;
      if (disp_blank !== 1'b1) begin n_fail++; $display("FAIL clear_min_blank: got %0b expected 1", disp_blank); end
      press_next();
      n_checks++;
      if (disp_data !== 8'd18 || disp_unit !== 2'd0 || disp_blank !== 1'b0)
         begin n_fail++; $display("FAIL clear_c_view: got data=%0d unit=%0d blank=%0b expected 18/0/0", disp_data, disp_unit, disp_blank); end
      press_next();
      press_next();
      n_checks++;
      if (disp_unit !== 2'd2 || disp_blank !== 1'b1)
         begin n_fail++; $display("FAIL clear_max_blank: got unit=%0d blank=%0b expected 2/1", disp_unit, disp_blank); end
      send_sample(8'd25, 8'd70);
      tick();
      n_checks++;
      if (disp_data !== 8'd70 || disp_blank !== 1'b0)
         begin n_fail++; $display("FAIL reinit_max: got data=%0d blank=%0b expected 70/0", disp_data, disp_blank); end
      press_next();
      n_checks++;
      if (disp_data !== 8'd70 || disp_unit !== 2'd3)
         begin n_fail++; $display("FAIL reinit_min: got data=%0d unit=%0d expected 70/3", disp_data, disp_unit); end
      clear_mm = 1'b1;
      send_sample(8'd26, 8'd90);
      clear_mm = 1'b0;
      tick();
      n_checks++;
      if (disp_data !== 8'd90 || disp_blank !== 1'b0)
         begin n_fail++; $display("FAIL clear_with_sample: got data=%0d blank=%0b expected 90/0", disp_data, disp_blank); end
      send_sample(8'd26, 8'd95);
      tick();
      n_checks++;
      if (disp_data !== 8'd90) begin n_fail++; $display("FAIL min_holds: got %0d expected 90", disp_data); end
   endtask

   task automatic test_held_button();
      btn_next = 1'b1;
      tick(5);
      btn_next = 1'b0;
      tick();
      n_checks++;
      if (disp_unit !== 2'd0 || disp_data !== 8'd26)
         begin n_fail++; $display("FAIL held_btn: got unit=%0d data=%0d expected 0/26", disp_unit, disp_data); end
   endtask

   task automatic test_auto();
      send_sample(8'd26, 8'd95);
      btn_auto = 1'b1;
      tick(10);
      n_checks++;
      if (disp_unit !== 2'd0) begin n_fail++; $display("FAIL auto_hold_c: got unit=%0d expected 0", disp_unit); end
      tick();
      n_checks++;
      if (disp_unit !== 2'd1 || disp_data !== 8'd95)
         begin n_fail++; $display("FAIL auto_to_f: got unit=%0d data=%0d expected 1/95", disp_unit, disp_data); end
      tick(9);
      n_checks++;
      if (disp_unit !== 2'd1) begin n_fail++; $display("FAIL auto_hold_f: got unit=%0d expected 1", disp_unit); end
      tick();
      n_checks++;
      if (disp_unit !== 2'd2) begin n_fail++; $display("FAIL auto_to_max: got unit=%0d expected 2", disp_unit); end
      tick(8);
      btn_next = 1'b1;
      c_data = 8'd26; f_data = 8'd95; sample_valid = 1'b1;
      tick();
      btn_next = 1'b0;
      sample_valid = 1'b0;
      tick();
      n_checks++;
      if (disp_unit !== 2'd3 || disp_data !== 8'd90)
         begin n_fail++; $display("FAIL expiry_btn: got unit=%0d data=%0d expected 3/90", disp_unit, disp_data); end
      tick(9);
      n_checks++;
      if (disp_unit !== 2'd3) begin n_fail++; $display("FAIL expiry_hold: got unit=%0d expected 3", disp_unit); end
      tick();
      n_checks++;
      if (disp_unit !== 2'd0) begin n_fail++; $display("FAIL auto_wrap: got unit=%0d expected 0", disp_unit); end
      btn_auto = 1'b0;
      tick(20);
      n_checks++;
      if (disp_unit !== 2'd0 || disp_blank !== 1'b0)
         begin n_fail++; $display("FAIL manual_hold: got unit=%0d blank=%0b expected 0/0", disp_unit, disp_blank); end
   endtask

   task automatic test_stale();
      send_sample(8'd27, 8'd80);
      tick(49);
      n_checks++;
      if (disp_blank !== 1'b0) begin n_fail++; $display("FAIL stale_early: got %0b expected 0", disp_blank); end
      tick();
      n_checks++;
      if (disp_blank !== 1'b1) begin n_fail++; $display("FAIL stale_blank: got %0b expected 1", disp_blank); end
      send_sample(8'd30, 8'd86);
      tick();
      n_checks++;
      if (disp_blank !== 1'b0 || disp_data !== 8'd30 || disp_unit !== 2'd0)
         begin n_fail++; $display("FAIL stale_resume: got blank=%0b data=%0d unit=%0d expected 0/30/0", disp_blank, disp_data, disp_unit); end
   endtask

   task automatic test_reset_mid();
      btn_auto = 1'b1;
      tick(15);
      reset = 1'b1;
      #1;
      n_checks++;
      if (disp_blank !== 1'b1 || disp_data !== 8'd0 || disp_unit !== 2'd0 || sample_ack !== 1'b0)
         begin n_fail++; $display("FAIL async_reset: got blank=%0b data=%0d unit=%0d ack=%0b expected 1/0/0/0", disp_blank, disp_data, disp_unit, sample_ack); end
      btn_auto = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      send_sample(8'd21, 8'd70);
      tick();
      n_checks++;
      if (disp_data !== 8'd21 || disp_unit !== 2'd0 || disp_blank !== 1'b0 || sample_ack !== 1'b1)
         begin n_fail++; $display("FAIL post_reset_c: got data=%0d unit=%0d blank=%0b ack=%0b expected 21/0/0/1", disp_data, disp_unit, disp_blank, sample_ack); end
      press_next();
      press_next();
      n_checks++;
      if (disp_data !== 8'd70 || disp_unit !== 2'd2 || disp_blank !== 1'b0)
         begin n_fail++; $display("FAIL post_reset_max: got data=%0d unit=%0d blank=%0b expected 70/2/0", disp_data, disp_unit, disp_blank); end
   endtask

   initial begin
      test_reset();
      test_first_sample();
      test_back_to_back();
      test_minmax();
      test_held_button();
      test_auto();
      test_stale();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
